// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10
  } state_t;

  // ALU operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResReadData  = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  // funct3 values the ALU decoder understands for R/I-type arithmetic
  function automatic logic alu_funct3_legal(input logic [2:0] funct3);
    case (funct3)
      3'b000, 3'b010, 3'b100, 3'b110, 3'b111: alu_funct3_legal = 1'b1;
      default:                                 alu_funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction fields to an alu_control code.
module alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  alu_op_e               i_alu_op,
  input  logic [2:0]            i_funct3,
  input  logic                  i_op_b5,
  input  logic                  i_funct7_b5,
  output logic [ALU_CTRL_W-1:0] o_alu_control
);

  logic [2:0] w_code;

  // Decode the 3-bit ALU code; unknown funct3 falls back to add (DECODE traps it anyway)
  always_comb begin
    w_code = AluAdd;
    case (i_alu_op)
      AluOpSub: w_code = AluSub;
      AluOpFunct: begin
        case (i_funct3)
          // op[5] separates R-type from I-type so addi never becomes sub
          3'b000:  w_code = (i_op_b5 && i_funct7_b5) ? AluSub : AluAdd;
          3'b010:  w_code = AluSlt;
          3'b100:  w_code = AluXor;
          3'b110:  w_code = AluOr;
          3'b111:  w_code = AluAnd;
          default: w_code = AluAdd;
        endcase
      end
      default: w_code = AluAdd;
    endcase
  end

  assign o_alu_control = ALU_CTRL_W'(w_code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter bit          EN_BNE     = 1'b1,
  parameter bit          EN_JAL     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            i_op,
  input  logic [2:0]            i_funct3,
  input  logic                  i_funct7_b5,
  input  logic                  i_zero,
  output logic                  o_pc_write,
  output logic                  o_adr_src,
  output logic                  o_mem_write,
  output logic                  o_ir_write,
  output logic [1:0]            o_result_src,
  output logic [1:0]            o_alu_src_a,
  output logic [1:0]            o_alu_src_b,
  output logic [1:0]            o_imm_src,
  output logic                  o_reg_write,
  output logic [ALU_CTRL_W-1:0] o_alu_control,
  output logic                  o_instr_done,
  output logic                  o_illegal_op
);

  state_t     r_state, w_next_state;
  alu_op_e    w_alu_op;
  logic       w_legal;
  logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
  logic       w_instr_done, w_illegal_op;
  logic [1:0] w_result_src, w_src_a, w_src_b, w_imm_src;

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StFetch;
    else     r_state <= w_next_state;
  end

  // Opcode/funct3 legality, checked while in DECODE
  always_comb begin
    w_legal = 1'b0;
    case (i_op)
      OpLoad, OpStore:  w_legal = 1'b1;
      OpRType, OpIType: w_legal = alu_funct3_legal(i_funct3);
      OpBranch:         w_legal = (i_funct3 == 3'b000) || (EN_BNE && (i_funct3 == 3'b001));
      OpJal:            w_legal = EN_JAL;
      default:          w_legal = 1'b0;
    endcase
  end

  // Immediate format follows the opcode directly, independent of state
  always_comb begin
    w_imm_src = ImmI;
    case (i_op)
      OpStore:  w_imm_src = ImmS;
      OpBranch: w_imm_src = ImmB;
      OpJal:    w_imm_src = ImmJ;
      default:  w_imm_src = ImmI;
    endcase
  end

  // Next-state and Moore outputs; unknown encodings fall to default (all off, go FETCH)
  always_comb begin
    w_next_state = StFetch;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_instr_done = 1'b0;
    w_illegal_op = 1'b0;
    w_result_src = ResAluOut;
    w_src_a      = SrcAPc;
    w_src_b      = SrcBRd2;
    w_alu_op     = AluOpAdd;
    case (r_state)
      StFetch: begin
        w_ir_write   = 1'b1;
        w_pc_write   = 1'b1;
        w_src_b      = SrcBFour;
        w_result_src = ResAluResult;
        w_next_state = StDecode;
      end
      StDecode: begin
        // OldPC + imm lands in ALUOut as the branch/jump target
        w_src_a = SrcAOldPc;
        w_src_b = SrcBImm;
        if (!w_legal) begin
          w_illegal_op = 1'b1;
        end else begin
          case (i_op)
            OpLoad, OpStore: w_next_state = StMemAdr;
            OpRType:         w_next_state = StExecR;
            OpIType:         w_next_state = StExecI;
            OpBranch:        w_next_state = StBranch;
            OpJal:           w_next_state = StJal;
            default:         w_next_state = StFetch;
          endcase
        end
      end
      StMemAdr: begin
        w_src_a      = SrcARd1;
        w_src_b      = SrcBImm;
        w_next_state = (i_op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        w_adr_src    = 1'b1;
        w_next_state = StMemWb;
      end
      StMemWb: begin
        w_result_src = ResReadData;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      StMemWrite: begin
        w_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      StExecR: begin
        w_src_a      = SrcARd1;
        w_alu_op     = AluOpFunct;
        w_next_state = StAluWb;
      end
      StExecI: begin
        w_src_a      = SrcARd1;
        w_src_b      = SrcBImm;
        w_alu_op     = AluOpFunct;
        w_next_state = StAluWb;
      end
      StAluWb: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      StBranch: begin
        // funct3[0] inverts the condition: beq takes on zero, bne on nonzero
        w_src_a      = SrcARd1;
        w_alu_op     = AluOpSub;
        w_pc_write   = i_zero ^ i_funct3[0];
        w_instr_done = 1'b1;
      end
      StJal: begin
        // PC+4 computed for the link; PC itself loads the target already in ALUOut
        w_src_a      = SrcAOldPc;
        w_src_b      = SrcBFour;
        w_pc_write   = 1'b1;
        w_next_state = StAluWb;
      end
      default: w_next_state = StFetch;
    endcase
  end

  alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_decoder (
    .i_alu_op     (w_alu_op),
    .i_funct3     (i_funct3),
    .i_op_b5      (i_op[5]),
    .i_funct7_b5  (i_funct7_b5),
    .o_alu_control(o_alu_control)
  );

  // Hold every enable and mux select at zero while reset is asserted
  always_comb begin
    o_pc_write   = w_pc_write & ~rst;
    o_adr_src    = w_adr_src & ~rst;
    o_mem_write  = w_mem_write & ~rst;
    o_ir_write   = w_ir_write & ~rst;
    o_reg_write  = w_reg_write & ~rst;
    o_instr_done = w_instr_done & ~rst;
    o_illegal_op = w_illegal_op & ~rst;
    o_result_src = rst ? 2'b00 : w_result_src;
    o_alu_src_a  = rst ? 2'b00 : w_src_a;
    o_alu_src_b  = rst ? 2'b00 : w_src_b;
    o_imm_src    = rst ? 2'b00 : w_imm_src;
  end

endmodule
